cpu_core_ctl: RTL and testbench

//  Parametrised single-cycle CPU core with run/step/halt control, loadable instruction memory,
//  a debug register read port and a retired-instruction counter. It succeeds the fixed-width core
//  and adds configurable register width, register count and IMEM depth, plus run/pause/step execution

---
 rtl/cpu_core_ctl.sv | 130 +++++++++++++
 tb/tb_cpu_core_ctl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_ctl.sv
// Parametrised single-cycle CPU core with run/step/halt control, loadable IMEM and debug read port.
// One instruction commits per CLK edge while executing; IMEM writes are accepted only when not running.
module cpu_core_ctl #(
  parameter int REG_WIDTH  = 16,
  parameter int NUM_REGS   = 8,
  parameter int IMEM_DEPTH = 64,
  parameter int RET_WIDTH  = 32,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int RI_W      = $clog2(NUM_REGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 imem_we,
  input  logic [PC_W-1:0]      imem_waddr,
  input  logic [15:0]          imem_wdata,
  input  logic                 run,
  input  logic                 step,
  input  logic [2:0]           dbg_raddr,
  output logic [REG_WIDTH-1:0] dbg_rdata,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  output logic                 running,
  output logic [RET_WIDTH-1:0] retired
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [PC_W-1:0]      PC_ONE  = PC_W'(1);
  localparam logic [RET_WIDTH-1:0] RET_ONE = RET_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [RET_WIDTH-1:0] ret_q, ret_d;
  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
  logic [15:0]          imem [IMEM_DEPTH];

  logic [15:0]          instr;
  logic [3:0]           op;
  logic [RI_W-1:0]      rd_idx, rs_idx;
  logic [5:0]           imm;
  logic [REG_WIDTH-1:0] sx_reg, rd_val, rs_val, wr_val;
  logic [PC_W-1:0]      pc_sx;
  logic                 exec, wr_en;

  assign instr  = imem[pc_q];
  assign op     = instr[15:12];
  assign rd_idx = instr[9 +: RI_W];
  assign rs_idx = instr[6 +: RI_W];
  assign imm    = instr[5:0];
  assign sx_reg = {{(REG_WIDTH-6){imm[5]}}, imm};
  assign rd_val = regs_q[rd_idx];
  assign rs_val = regs_q[rs_idx];

  // Branch offset folded to PC width so pc arithmetic wraps modulo IMEM_DEPTH.
  generate
    if (PC_W <= 6) begin : g_pc_trunc
      assign pc_sx = imm[PC_W-1:0];
    end else begin : g_pc_sext
      assign pc_sx = {{(PC_W-6){imm[5]}}, imm};
    end
  endgenerate

  // IDLE with run and step together transitions to RUN without executing.
  assign exec = ((state_q == S_RUN) && run) ||
                ((state_q == S_IDLE) && !run && step);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    wr_en   = 1'b0;
    wr_val  = rd_val;
    case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_IDLE;
      default: ;
    endcase
    if (exec) begin
      if (op == 4'h0) begin
        state_d = S_HALTED;
      end else begin
        pc_d = pc_q + PC_ONE;
        if (ret_q != '1) ret_d = ret_q + RET_ONE;
        case (op)
          4'h1: begin wr_en = 1'b1; wr_val = rd_val + sx_reg; end
          4'h2: begin wr_en = 1'b1; wr_val = rd_val + rs_val; end
          4'h3: begin wr_en = 1'b1; wr_val = rd_val - rs_val; end
          4'h4: if (rd_val != '0) pc_d = pc_q + pc_sx;
          4'h5: pc_d = pc_q + pc_sx;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_idx] <= wr_val;
    end
  end

  // IMEM survives reset; writes are dropped while running.
  always_ff @(posedge CLK) begin
    if (imem_we && ((state_q == S_IDLE) || (state_q == S_HALTED)))
      imem[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = regs_q[dbg_raddr[RI_W-1:0]];
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALTED);
  assign running   = (state_q == S_RUN);
  assign retired   = ret_q;

endmodule

// File: tb/tb_cpu_core_ctl.sv
// Bench for cpu_core_ctl: directed scenarios plus randomized programs/controls checked against
// an instruction-level reference model.
module tb_cpu_core_ctl;
  localparam int RW   = 8;
  localparam int NR   = 8;
  localparam int DEP  = 64;
  localparam int RETW = 4;
  localparam int PCW  = 6;
  localparam int RMAX = (1 << RETW) - 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic            imem_we;
  logic [PCW-1:0]  imem_waddr;
  logic [15:0]     imem_wdata;
  logic            run, step;
  logic [2:0]      dbg_raddr;
  logic [RW-1:0]   dbg_rdata;
  logic [PCW-1:0]  pc;
  logic            halted, running;
  logic [RETW-1:0] retired;

  cpu_core_ctl #(.REG_WIDTH(RW), .NUM_REGS(NR), .IMEM_DEPTH(DEP), .RET_WIDTH(RETW)) dut (
    .CLK(CLK), .RST(RST), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .run(run), .step(step), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
    .halted(halted), .running(running), .retired(retired)
  );

  always #20 CLK = ~CLK;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: architectural state in plain integers.
  logic [15:0] m_mem [DEP];
  int          m_reg [NR];
  int          m_pc, m_ret;
  bit          m_run, m_halt;
  logic [15:0] prog [$];

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), m_pc);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("running", 32'(running), 32'(m_run));
    chk("retired", 32'(retired), m_ret);
    for (int i = 0; i < NR; i++) begin
      dbg_raddr = 3'(i);
      #1;
      chk($sformatf("r%0d", i), 32'(dbg_rdata), m_reg[i]);
    end
  endtask

  task automatic m_exec();
    logic [15:0] w;
    int op, rd, rs, sx, nxt;
    w  = m_mem[m_pc];
    op = int'(w[15:12]);
    rd = int'(w[11:9]);
    rs = int'(w[8:6]);
    sx = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
    if (op == 0) begin
      m_halt = 1'b1;
      m_run  = 1'b0;
      return;
    end
    m_ret = (m_ret < RMAX) ? m_ret + 1 : RMAX;
    nxt = m_pc + 1;
    case (op)
      1: m_reg[rd] = wrap(m_reg[rd] + sx, 1 << RW);
      2: m_reg[rd] = wrap(m_reg[rd] + m_reg[rs], 1 << RW);
      3: m_reg[rd] = wrap(m_reg[rd] - m_reg[rs], 1 << RW);
      4: if (m_reg[rd] != 0) nxt = m_pc + sx;
      5: nxt = m_pc + sx;
      default: ;
    endcase
    m_pc = wrap(nxt, DEP);
  endtask

  task automatic m_edge(input bit r, input bit s, input bit we, input int wa, input logic [15:0] wd);
    bit was_run;
    was_run = m_run;
    if (m_halt) begin
    end else if (m_run) begin
      if (!r) m_run = 1'b0;
      else m_exec();
    end else begin
      if (r) m_run = 1'b1;
      else if (s) m_exec();
    end
    if (we && !was_run) m_mem[wa] = wd;
  endtask

  task automatic cyc(input bit r, input bit s, input bit we = 1'b0, input int wa = 0,
                     input logic [15:0] wd = 16'h0);
    run = r; step = s; imem_we = we; imem_waddr = PCW'(wa); imem_wdata = wd;
    m_edge(r, s, we, wa, wd);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; state must clear without waiting for a clock.
  task automatic do_reset();
    RST = 1'b1;
    m_pc = 0; m_ret = 0; m_run = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
    #1;
    check_all();
    RST = 1'b0;
    run = 1'b0; step = 1'b0; imem_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) cyc(1'b0, 1'b0, 1'b1, i, prog[i]);
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    dbg_raddr = 3'(idx);
    #1;
    v = 32'(dbg_rdata);
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !m_halt; i++) cyc(1'b1, 1'b0);
  endtask

  logic [31:0] v;

  initial begin
    RST = 1'b1; run = 1'b0; step = 1'b0; imem_we = 1'b0;
    imem_waddr = '0; imem_wdata = '0; dbg_raddr = '0;
    for (int a = 0; a < DEP; a++) m_mem[a] = 16'hF000;
    do_reset();
    for (int a = 0; a < DEP; a++) cyc(1'b0, 1'b0, 1'b1, a, 16'hF000);

    // HALT via single step, further steps have no effect
    prog = '{16'h0000};
    load_prog();
    cyc(1'b0, 1'b1);
    chk("t1_halted", 32'(halted), 1);
    cyc(1'b0, 1'b1);
    chk("t1_pc", 32'(pc), 0);
    chk("t1_retired", 32'(retired), 0);

    // ADDI/NOP/ADDI/HALT
    do_reset();
    prog = '{16'h1001, 16'hF000, 16'h1001, 16'h0000};
    load_prog();
    run_until_halt(10);
    rd_reg(0, v);
    chk("t2_r0", v, 2);
    chk("t2_pc", 32'(pc), 3);
    chk("t2_retired", 32'(retired), 3);

    // countdown loop
    do_reset();
    prog = '{16'h1203, 16'h123F, 16'h423F, 16'h0000};
    load_prog();
    run_until_halt(30);
    chk("t3_halted", 32'(halted), 1);
    rd_reg(1, v);
    chk("t3_r1", v, 0);
    chk("t3_pc", 32'(pc), 3);
    chk("t3_retired", 32'(retired), 7);

    // 8-bit wrap of ADDI r2,31 x9
    do_reset();
    prog = {};
    for (int i = 0; i < 9; i++) prog.push_back(16'h141F);
    prog.push_back(16'h0000);
    load_prog();
    run_until_halt(20);
    rd_reg(2, v);
    chk("t4_r2_wrap", v, 23);
    chk("t4_retired", 32'(retired), 9);

    // JMP -1 at pc 0 wraps to the top of IMEM
    do_reset();
    prog = '{16'h503F};
    load_prog();
    cyc(1'b0, 1'b1);
    chk("t4_pc_wrap", 32'(pc), DEP - 1);

    // retired saturates
    do_reset();
    prog = '{16'h5000};
    load_prog();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    chk("sat_retired", 32'(retired), RMAX);
    cyc(1'b0, 1'b0);
    chk("sat_pause", 32'(running), 0);

    // pause, write dropped in RUN, write at pc in IDLE, run+step together
    do_reset();
    prog = '{16'h1601, 16'h1601, 16'h1601, 16'h1601, 16'h1601, 16'h0000};
    load_prog();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4, 16'h0000);
    cyc(1'b0, 1'b0);
    chk("t5_idle", 32'(running), 0);
    chk("t5_pc", 32'(pc), 3);
    cyc(1'b0, 1'b0, 1'b1, 3, 16'h1602);
    cyc(1'b1, 1'b1);
    chk("t5_runstep_running", 32'(running), 1);
    chk("t5_runstep_pc", 32'(pc), 3);
    run_until_halt(10);
    rd_reg(3, v);
    chk("t5_r3", v, 6);
    chk("t5_retired", 32'(retired), 5);

    // reset mid-run then rerun the preserved program
    do_reset();
    prog = '{16'h1601, 16'h141F, 16'h0000};
    load_prog();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    do_reset();
    chk("t6_pc_rst", 32'(pc), 0);
    run_until_halt(10);
    rd_reg(3, v);
    chk("t6_r3", v, 1);
    rd_reg(2, v);
    chk("t6_r2", v, 31);
    chk("t6_retired", 32'(retired), 2);

    // randomized programs and control
    for (int rnd = 0; rnd < 6; rnd++) begin
      do_reset();
      for (int a = 0; a < DEP; a++) begin
        logic [15:0] w;
        w = 16'($urandom);
        w[15:12] = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        cyc(1'b0, 1'b0, 1'b1, a, w);
      end
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 59) == 0) do_reset();
        cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
            int'($urandom_range(0, DEP - 1)), 16'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
